huffman_tree_builder: RTL
=========================

Name: huffman_tree_builder

Overview:
Parametrised successor to the fixed 6-node table builder. It accepts NSYM (symbol, frequency) pairs, then repeatedly merges the two lowest-frequency head nodes until one root remains. Tree construction is a sequential scan-and-merge engine. After the build, a query port walks a leaf-to-root path and returns each symbol's code length, plus its codeword when the optional feature is compiled in. It sits between the frequency counter and the encoder table.

Parameters:
NSYM, 6, maximum number of leaf symbols (≥2)
SYM_W, 8, symbol (ascii) width
FREQ_W, 32, frequency width; internal sums saturate at 2^FREQ_W-1
IDX_W, $clog2(2*NSYM-1), node index width (derived)
LEN_W, $clog2(NSYM), code length width (derived)

Ports:
clk  in  1  clock, rising-edge
ctrl_reset_n  in  1  asynchronous active-low reset
ld_valid  in  1  leaf load request
ld_ascii  in  SYM_W  leaf symbol
ld_freq  in  FREQ_W  leaf frequency
ld_ready  out  1  leaf load accepted when ld_valid&ld_ready
ctrl_start  in  1  begin build (one-cycle pulse, sampled in IDLE only)
ctrl_clear  in  1  return to IDLE, discard all nodes
busy  out  1  build in progress
done  out  1  tree complete, queries allowed
err  out  1  sticky: start issued with fewer than 2 leaves; cleared by ctrl_clear
root_freq  out  FREQ_W  frequency of root, valid while done
q_valid  in  1  query request
q_index  in  IDX_W  leaf index (load order, 0-based)
q_ready  out  1  query accepted when q_valid&q_ready
r_valid  out  1  response valid, held until r_ready
r_ready  in  1  response consumed
r_ascii  out  SYM_W  symbol of queried leaf
r_len  out  LEN_W  code length

Behaviour:
- Reset (async, ctrl_reset_n=0): state IDLE, leaf count=0, node count=0; ld_ready=1, busy=0, done=0, err=0, root_freq=0, q_ready=0, r_valid=0, r_ascii=0, r_len=0 (r_code=0). Reset mid-build or mid-walk aborts immediately.
- Node storage: 2*NSYM-1 entries, each {ascii, freq, parent, branch bit, head}.
- States: IDLE, SCAN, MERGE, DONE, WALK, RESP.
- IDLE:
  - ld_ready=1 while leaf count<NSYM.
  - An accepted load writes a leaf at index=count with head=1, then increments count; loads beyond NSYM are blocked (ld_ready=0).
  - ctrl_start with count≥2 -> SCAN, busy=1.
  - ctrl_start with count<2 -> err=1, stay in IDLE.
- SCAN: visits one node per cycle, index 0..nodes-1, tracking min1 ≤ min2 among head nodes. On equal frequency the lower index wins. Zero-frequency leaves participate normally.
- MERGE (1 cycle):
  - New node at index=nodes, freq=sat(f(min1)+f(min2)), head=1.
  - min1.parent=new, branch bit 0; min2.parent=new, branch bit 1; both head=0.
  - nodes++. If head count becomes 1 -> DONE, else -> SCAN.
- Build latency: sum over rounds of (nodes+1) cycles; n leaves need n-1 rounds.
- DONE: busy=0, done=1, root_freq=root freq, q_ready=1.
- Query:
  - q_index≥leaf count returns r_len=0.
  - A valid query moves to WALK (q_ready=0), which follows one parent link per cycle until the root, counting edges; then -> RESP.
- RESP: r_valid=1 with r_ascii and r_len stable until r_ready, then -> DONE.
- Input precedence:
  - ctrl_start outside IDLE is ignored.
  - ctrl_clear in any state -> IDLE next cycle with counts zeroed and outputs at reset values. It takes priority over same-cycle ld_valid, ctrl_start and q_valid.

Optional Feature:
HUFF_CODEWORD_EN:
- Defined: adds output r_code (NSYM-1 bits). The walk inserts each branch bit at position depth, yielding the root-to-leaf codeword MSB-first in the low r_len bits, upper bits 0. Walk latency is unchanged.
- Undefined: port absent, branch bits still stored.

Test Plan:
- Load 5,9,12,13,16,45 (ascii 'a'..'f'), pulse start -> busy for exactly 45 cycles (40 scan + 5 merge), then done=1, root_freq=100; merge sums in order 14,25,30,55,100.
- Query each leaf of that tree -> r_len = 4,4,3,3,3,1; with HUFF_CODEWORD_EN, r_code = 1100,1101,100,101,111,0.
- Load 7,7 then start -> one merge, root_freq=14; leaf 0 len 1 code 0, leaf 1 len 1 code 1 (tie → lower index is branch 0).
- Load one leaf, pulse start -> err=1, stays IDLE, busy never set; ctrl_clear -> err=0, ld_ready=1.
- FREQ_W=8, load 200,200,200 -> first sum saturates to 255, root_freq=255, no wrap.
- Deassert ctrl_reset_n during SCAN, and separately hold r_ready=0 during RESP -> reset returns all outputs to reset values within the cycle; the held response keeps r_valid/r_len stable until r_ready.

Source files
------------

// File: rtl/huffman_tree_builder_if.sv
// Load, query and response handshakes of the Huffman tree builder.
// r_code exists only when HUFF_CODEWORD_EN is defined.
interface huffman_tree_builder_if #(
    parameter int NSYM   = 6,
    parameter int SYM_W  = 8,
    parameter int FREQ_W = 32,
    parameter int IDX_W  = $clog2(2*NSYM-1),
    parameter int LEN_W  = $clog2(NSYM)
);
    logic              ld_valid;
    logic [SYM_W-1:0]  ld_ascii;
    logic [FREQ_W-1:0] ld_freq;
    logic              ld_ready;
    logic              q_valid;
    logic [IDX_W-1:0]  q_index;
    logic              q_ready;
    logic              r_valid;
    logic              r_ready;
    logic [SYM_W-1:0]  r_ascii;
    logic [LEN_W-1:0]  r_len;
`ifdef HUFF_CODEWORD_EN
    logic [NSYM-2:0]   r_code;
`endif

    modport master (
        output ld_valid, ld_ascii, ld_freq, q_valid, q_index, r_ready,
        input  ld_ready, q_ready, r_valid, r_ascii, r_len
`ifdef HUFF_CODEWORD_EN
        , input r_code
`endif
    );

    modport slave (
        input  ld_valid, ld_ascii, ld_freq, q_valid, q_index, r_ready,
        output ld_ready, q_ready, r_valid, r_ascii, r_len
`ifdef HUFF_CODEWORD_EN
        , output r_code
`endif
    );
endinterface

// File: rtl/huffman_tree_builder.sv
// Sequential scan-and-merge Huffman tree builder with a leaf-to-root code length query.
// Optional macro HUFF_CODEWORD_EN adds the root-to-leaf codeword on r_code.
module huffman_tree_builder #(
    parameter int NSYM   = 6,
    parameter int SYM_W  = 8,
    parameter int FREQ_W = 32,
    parameter int IDX_W  = $clog2(2*NSYM-1),
    parameter int LEN_W  = $clog2(NSYM)
) (
    input  logic                  clk,
    input  logic                  ctrl_reset_n,
    huffman_tree_builder_if.slave bus,
    input  logic                  ctrl_start,
    input  logic                  ctrl_clear,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [FREQ_W-1:0]     root_freq
);
    localparam int NNODE = 2*NSYM-1;
    localparam logic [IDX_W-1:0] NSYM_I = IDX_W'(NSYM);
    localparam logic [IDX_W-1:0] ONE_I  = IDX_W'(1);
    localparam logic [IDX_W-1:0] TWO_I  = IDX_W'(2);

    typedef enum logic [2:0] {IDLE, SCAN, MERGE, DONE, WALK, RESP} state_t;
    state_t stateReg, stateNext;

    logic [SYM_W-1:0]  nodeAscii  [NNODE];
    logic [FREQ_W-1:0] nodeFreq   [NNODE];
    logic [IDX_W-1:0]  nodeParent [NNODE];
    logic              nodeBranch [NNODE];
    logic              nodeHead   [NNODE];

    logic [IDX_W-1:0]  leafCnt, nodeCnt, headCnt, scanIdx, walkCur;
    logic [IDX_W-1:0]  min1Idx, min2Idx;
    logic [FREQ_W-1:0] min1Freq, min2Freq;
    logic              min1Ok, min2Ok;
    logic [FREQ_W-1:0] rootFreq;
    logic              errReg;
    logic [SYM_W-1:0]  rAscii;
    logic [LEN_W-1:0]  rLen;
`ifdef HUFF_CODEWORD_EN
    logic [NSYM-2:0]   rCode;
`else
    logic              walkBranchUnused;
    assign walkBranchUnused = nodeBranch[walkCur];
`endif

    logic              loadFire;
    logic [IDX_W-1:0]  effCnt;
    logic [FREQ_W:0]   mergeSum;
    logic [FREQ_W-1:0] mergeFreq;

    assign bus.ld_ready = (stateReg == IDLE) && (leafCnt < NSYM_I);
    assign bus.q_ready  = (stateReg == DONE);
    assign bus.r_valid  = (stateReg == RESP);
    assign bus.r_ascii  = rAscii;
    assign bus.r_len    = rLen;
`ifdef HUFF_CODEWORD_EN
    assign bus.r_code   = rCode;
`endif
    assign busy      = (stateReg == SCAN) || (stateReg == MERGE);
    assign done      = (stateReg == DONE) || (stateReg == WALK) || (stateReg == RESP);
    assign err       = errReg;
    assign root_freq = rootFreq;

    assign loadFire  = bus.ld_valid && bus.ld_ready && !ctrl_clear;
    // A leaf loaded in the same cycle as start joins the build.
    assign effCnt    = leafCnt + IDX_W'(loadFire);
    assign mergeSum  = {1'b0, min1Freq} + {1'b0, min2Freq};
    assign mergeFreq = mergeSum[FREQ_W] ? {FREQ_W{1'b1}} : mergeSum[FREQ_W-1:0];

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (ctrl_start && effCnt >= TWO_I) stateNext = SCAN;
            SCAN:    if (scanIdx == nodeCnt - ONE_I) stateNext = MERGE;
            MERGE:   stateNext = (headCnt == TWO_I) ? DONE : SCAN;
            DONE:    if (bus.q_valid) stateNext = WALK;
            WALK:    if (nodeHead[walkCur]) stateNext = RESP;
            RESP:    if (bus.r_ready) stateNext = DONE;
            default: stateNext = IDLE;
        endcase
        if (ctrl_clear) stateNext = IDLE;
    end

    // Node storage carries no reset: the counters decide which entries are live.
    always_ff @(posedge clk) begin
        if (loadFire) begin
            nodeAscii[leafCnt] <= bus.ld_ascii;
            nodeFreq[leafCnt]  <= bus.ld_freq;
            nodeHead[leafCnt]  <= 1'b1;
        end
        if (stateReg == MERGE && !ctrl_clear) begin
            nodeAscii[nodeCnt]  <= '0;
            nodeFreq[nodeCnt]   <= mergeFreq;
            nodeHead[nodeCnt]   <= 1'b1;
            nodeParent[min1Idx] <= nodeCnt;
            nodeBranch[min1Idx] <= 1'b0;
            nodeHead[min1Idx]   <= 1'b0;
            nodeParent[min2Idx] <= nodeCnt;
            nodeBranch[min2Idx] <= 1'b1;
            nodeHead[min2Idx]   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            stateReg <= IDLE;
            leafCnt  <= '0;  nodeCnt  <= '0;  headCnt <= '0;
            scanIdx  <= '0;  walkCur  <= '0;
            min1Idx  <= '0;  min2Idx  <= '0;
            min1Freq <= '0;  min2Freq <= '0;
            min1Ok   <= 1'b0; min2Ok  <= 1'b0;
            rootFreq <= '0;  errReg   <= 1'b0;
            rAscii   <= '0;  rLen     <= '0;
`ifdef HUFF_CODEWORD_EN
            rCode    <= '0;
`endif
        end else begin
            stateReg <= stateNext;
            if (ctrl_clear) begin
                leafCnt  <= '0;  nodeCnt <= '0;  headCnt <= '0;
                rootFreq <= '0;  errReg  <= 1'b0;
                rAscii   <= '0;  rLen    <= '0;
`ifdef HUFF_CODEWORD_EN
                rCode    <= '0;
`endif
            end else begin
                case (stateReg)
                    IDLE: begin
                        if (loadFire) leafCnt <= leafCnt + ONE_I;
                        if (ctrl_start) begin
                            if (effCnt < TWO_I) begin
                                errReg <= 1'b1;
                            end else begin
                                nodeCnt <= effCnt;
                                headCnt <= effCnt;
                                scanIdx <= '0;
                                min1Ok  <= 1'b0;
                                min2Ok  <= 1'b0;
                            end
                        end
                    end
                    SCAN: begin
                        // Strict compare in ascending index order: ties keep the lower index.
                        if (nodeHead[scanIdx]) begin
                            if (!min1Ok || nodeFreq[scanIdx] < min1Freq) begin
                                min2Idx  <= min1Idx;
                                min2Freq <= min1Freq;
                                min2Ok   <= min1Ok;
                                min1Idx  <= scanIdx;
                                min1Freq <= nodeFreq[scanIdx];
                                min1Ok   <= 1'b1;
                            end else if (!min2Ok || nodeFreq[scanIdx] < min2Freq) begin
                                min2Idx  <= scanIdx;
                                min2Freq <= nodeFreq[scanIdx];
                                min2Ok   <= 1'b1;
                            end
                        end
                        scanIdx <= scanIdx + ONE_I;
                    end
                    MERGE: begin
                        nodeCnt <= nodeCnt + ONE_I;
                        headCnt <= headCnt - ONE_I;
                        scanIdx <= '0;
                        min1Ok  <= 1'b0;
                        min2Ok  <= 1'b0;
                        if (headCnt == TWO_I) rootFreq <= mergeFreq;
                    end
                    DONE: begin
                        if (bus.q_valid) begin
                            rLen <= '0;
`ifdef HUFF_CODEWORD_EN
                            rCode <= '0;
`endif
                            // Out-of-range queries start at the root and return length 0.
                            if (bus.q_index < leafCnt) begin
                                walkCur <= bus.q_index;
                                rAscii  <= nodeAscii[bus.q_index];
                            end else begin
                                walkCur <= nodeCnt - ONE_I;
                                rAscii  <= '0;
                            end
                        end
                    end
                    WALK: begin
                        if (!nodeHead[walkCur]) begin
                            rLen    <= rLen + LEN_W'(1);
`ifdef HUFF_CODEWORD_EN
                            rCode[rLen] <= nodeBranch[walkCur];
`endif
                            walkCur <= nodeParent[walkCur];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
